// File: rtl/cm0_dbg_wpt_array.sv
// Parametrised watchpoint/breakpoint comparator array for the Cortex-M0 debug
// sub-system: masked address compare, access-type select, match-count thresholds.
module cm0_dbg_wpt_array #(
    parameter int NCMP = 4,
    parameter int CNTW = 8
) (
    input  logic            dclk,
    input  logic            dbg_reset,
    input  logic            reg_sel_i,
    input  logic            reg_write_i,
    input  logic [5:0]      reg_addr_i,
    input  logic [31:0]     reg_wdata_i,
    output logic [31:0]     reg_rdata_o,
    input  logic            bus_trans_i,
    input  logic [31:0]     bus_addr_i,
    input  logic            bus_hprot_i,
    input  logic            bus_hwrite_i,
    input  logic            hready_i,
    input  logic            debugen_i,
    input  logic            halted_i,
    output logic            wpt_event_o,
    output logic            wpt_halt_req_o,
    output logic [NCMP-1:0] wpt_matched_o
);

    logic [31:0]     comp [NCMP];
    logic [4:0]      mask [NCMP];
    logic [3:0]      func [NCMP];
    logic [CNTW-1:0] cnt  [NCMP];
    logic [CNTW-1:0] cur  [NCMP];

    logic [NCMP-1:0] type_ok, match_d, match_q, ch_wr, fire, matched, w1c;
    logic            event_q, halt_q;
    logic [31:0]     rdata_q, rd_val;
    logic            sample, reg_wr, reg_rd, stat_sel;
    logic [2:0]      ch;
    logic [1:0]      fld;

    assign sample   = bus_trans_i & hready_i & debugen_i & ~halted_i;
    assign reg_wr   = reg_sel_i & reg_write_i;
    assign reg_rd   = reg_sel_i & ~reg_write_i;
    assign stat_sel = (reg_addr_i == 6'h20);
    assign ch       = reg_addr_i[4:2];
    assign fld      = reg_addr_i[1:0];
    assign w1c      = (reg_wr && stat_sel) ? reg_wdata_i[NCMP-1:0] : '0;

    always_comb begin
        type_ok = '0;
        match_d = '0;
        ch_wr   = '0;
        fire    = '0;
        for (int k = 0; k < NCMP; k++) begin
            ch_wr[k] = reg_wr & ~reg_addr_i[5] & (int'(ch) == k);
            case (func[k])
                4'd4:    type_ok[k] = ~bus_hprot_i;
                4'd5:    type_ok[k] = bus_hprot_i & ~bus_hwrite_i;
                4'd6:    type_ok[k] = bus_hprot_i & bus_hwrite_i;
                4'd7:    type_ok[k] = bus_hprot_i;
                default: type_ok[k] = 1'b0;
            endcase
            match_d[k] = sample & type_ok[k] &
                         (((bus_addr_i ^ comp[k]) & ~((32'h1 << mask[k]) - 32'h1)) == 32'h0);
            // A register write to the channel or loss of DEBUGEN kills the in-flight match.
            fire[k] = match_q[k] & ~ch_wr[k] & debugen_i & (cur[k] == '0);
        end
    end

    always_comb begin
        rd_val = '0;
        if (stat_sel) rd_val[NCMP-1:0] = matched;
        for (int k = 0; k < NCMP; k++) begin
            if (!reg_addr_i[5] && int'(ch) == k) begin
                case (fld)
                    2'd0:    rd_val = comp[k];
                    2'd1:    rd_val[4:0] = mask[k];
                    2'd2:    rd_val[3:0] = func[k];
                    default: rd_val[CNTW-1:0] = cnt[k];
                endcase
            end
        end
    end

    always_ff @(posedge dclk) begin
        if (dbg_reset) begin
            for (int k = 0; k < NCMP; k++) begin
                comp[k] <= '0;
                mask[k] <= '0;
                func[k] <= '0;
                cnt[k]  <= '0;
                cur[k]  <= '0;
            end
            match_q <= '0;
            matched <= '0;
            event_q <= 1'b0;
            halt_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            match_q <= match_d;
            event_q <= |fire;
            // A fire in the same cycle as a clear condition keeps the request asserted.
            if (|fire) halt_q <= 1'b1;
            else if (halted_i || !debugen_i) halt_q <= 1'b0;
            if (reg_rd) rdata_q <= rd_val;
            matched <= fire | (matched & ~w1c);
            for (int k = 0; k < NCMP; k++) begin
                if (ch_wr[k]) begin
                    case (fld)
                        2'd0:    comp[k] <= reg_wdata_i;
                        2'd1:    mask[k] <= reg_wdata_i[4:0];
                        2'd2:    func[k] <= reg_wdata_i[3:0];
                        default: cnt[k]  <= reg_wdata_i[CNTW-1:0];
                    endcase
                    cur[k] <= (fld == 2'd3) ? reg_wdata_i[CNTW-1:0] : cnt[k];
                end else if (match_q[k] && debugen_i) begin
                    cur[k] <= (cur[k] == '0) ? cnt[k] : cur[k] - CNTW'(1);
                end
            end
        end
    end

    assign reg_rdata_o    = rdata_q;
    assign wpt_event_o    = event_q;
    assign wpt_halt_req_o = halt_q;
    assign wpt_matched_o  = matched;

endmodule

// File: tb/tb_cm0_dbg_wpt_array.sv
// Directed bench for cm0_dbg_wpt_array: one task per scenario with inline checks.
// A second, two-channel instance shares all inputs for the bounds scenario.
module tb_cm0_dbg_wpt_array;

    logic        dclk = 1'b0;
    logic        dbg_reset = 1'b1;
    logic        reg_sel = 1'b0, reg_write = 1'b0;
    logic [5:0]  reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic        bus_trans = 1'b0, bus_hprot = 1'b0, bus_hwrite = 1'b0;
    logic [31:0] bus_addr = '0;
    logic        hready = 1'b1, debugen = 1'b1, halted = 1'b0;

    logic [31:0] rdata, rdata2;
    logic        evt, halt_req, evt2, halt_req2;
    logic [3:0]  matched;
    logic [1:0]  matched2;

    int checks = 0;
    int errors = 0;

    cm0_dbg_wpt_array #(.NCMP(4), .CNTW(8)) dut (
        .dclk(dclk), .dbg_reset(dbg_reset), .reg_sel_i(reg_sel), .reg_write_i(reg_write),
        .reg_addr_i(reg_addr), .reg_wdata_i(reg_wdata), .reg_rdata_o(rdata),
        .bus_trans_i(bus_trans), .bus_addr_i(bus_addr), .bus_hprot_i(bus_hprot),
        .bus_hwrite_i(bus_hwrite), .hready_i(hready), .debugen_i(debugen), .halted_i(halted),
        .wpt_event_o(evt), .wpt_halt_req_o(halt_req), .wpt_matched_o(matched)
    );

    cm0_dbg_wpt_array #(.NCMP(2), .CNTW(8)) dut2 (
        .dclk(dclk), .dbg_reset(dbg_reset), .reg_sel_i(reg_sel), .reg_write_i(reg_write),
        .reg_addr_i(reg_addr), .reg_wdata_i(reg_wdata), .reg_rdata_o(rdata2),
        .bus_trans_i(bus_trans), .bus_addr_i(bus_addr), .bus_hprot_i(bus_hprot),
        .bus_hwrite_i(bus_hwrite), .hready_i(hready), .debugen_i(debugen), .halted_i(halted),
        .wpt_event_o(evt2), .wpt_halt_req_o(halt_req2), .wpt_matched_o(matched2)
    );

    always #5 dclk = ~dclk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic reg_wr(input logic [5:0] a, input logic [31:0] d);
        reg_sel = 1'b1; reg_write = 1'b1; reg_addr = a; reg_wdata = d;
        tick();
        reg_sel = 1'b0; reg_write = 1'b0;
    endtask

    task automatic reg_rd(input logic [5:0] a);
        reg_sel = 1'b1; reg_write = 1'b0; reg_addr = a;
        tick();
        reg_sel = 1'b0;
    endtask

    // Presents one address phase; returns in cycle N+1 with the bus idle again.
    task automatic bus_acc(input logic [31:0] a, input logic hprot, input logic hwrite);
        bus_trans = 1'b1; bus_addr = a; bus_hprot = hprot; bus_hwrite = hwrite;
        tick();
        bus_trans = 1'b0;
    endtask

    task automatic clear_halt();
        halted = 1'b1;
        tick();
        halted = 1'b0;
    endtask

    task automatic prog_ch(input int k, input logic [31:0] c, input logic [4:0] m,
                           input logic [3:0] f, input logic [7:0] n);
        reg_wr(6'(4*k),     c);
        reg_wr(6'(4*k + 1), {27'd0, m});
        reg_wr(6'(4*k + 2), {28'd0, f});
        reg_wr(6'(4*k + 3), {24'd0, n});
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        dbg_reset = 1'b1;
        repeat (3) tick();
        dbg_reset = 1'b0;
        checks++; if (evt !== 1'b0) begin errors++; $display("FAIL reset_event got %0b exp 0", evt); end
        checks++; if (halt_req !== 1'b0) begin errors++; $display("FAIL reset_halt got %0b exp 0", halt_req); end
        checks++; if (matched !== 4'b0) begin errors++; $display("FAIL reset_matched got %b exp 0000", matched); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        reg_rd(6'd3);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_cnt0 got %h exp 0", rdata); end
    endtask

    task automatic test_exact();
        prog_ch(0, 32'h2000_0010, 5'd0, 4'd6, 8'd0);
        reg_rd(6'd0);
        checks++; if (rdata !== 32'h2000_0010) begin errors++; $display("FAIL exact_comp_rd got %h exp 20000010", rdata); end
        bus_acc(32'h2000_0010, 1'b1, 1'b1);
        checks++; if (evt !== 1'b0) begin errors++; $display("FAIL exact_evt_n1 got %0b exp 0", evt); end
        tick();
        checks++; if (evt !== 1'b1) begin errors++; $display("FAIL exact_evt_n2 got %0b exp 1", evt); end
        checks++; if (halt_req !== 1'b1) begin errors++; $display("FAIL exact_halt got %0b exp 1", halt_req); end
        checks++; if (matched !== 4'b0001) begin errors++; $display("FAIL exact_matched got %b exp 0001", matched); end
        tick();
        checks++; if (evt !== 1'b0) begin errors++; $display("FAIL exact_pulse_len got %0b exp 0", evt); end
        clear_halt();
        reg_wr(6'h20, 32'hF);
        bus_acc(32'h2000_0010, 1'b1, 1'b0);
        tick();
        checks++; if (evt !== 1'b0) begin errors++; $display("FAIL exact_read_no_evt got %0b exp 0", evt); end
        checks++; if (matched !== 4'b0000) begin errors++; $display("FAIL exact_read_matched got %b exp 0000", matched); end
    endtask

    task automatic test_mask_threshold();
        logic [31:0] seq [6];
        seq = '{32'h2000_0104, 32'h2000_010C, 32'h2000_0100,
                32'h2000_0110, 32'h2000_0110, 32'h2000_0110};
        prog_ch(1, 32'h2000_0100, 5'd4, 4'd7, 8'd2);
        for (int i = 0; i < 6; i++) begin
            bus_acc(seq[i], 1'b1, i[0]);
            tick();
            checks++;
            if (evt !== (i == 2)) begin
                errors++; $display("FAIL mask_seq%0d got %0b exp %0b", i, evt, (i == 2));
            end
        end
        checks++; if (matched !== 4'b0010) begin errors++; $display("FAIL mask_matched got %b exp 0010", matched); end
        clear_halt();
        reg_wr(6'h20, 32'hF);
        for (int i = 0; i < 3; i++) begin
            bus_acc(32'h2000_0108, 1'b1, 1'b0);
            tick();
            checks++;
            if (evt !== (i == 2)) begin
                errors++; $display("FAIL mask_reload%0d got %0b exp %0b", i, evt, (i == 2));
            end
        end
        clear_halt();
        reg_wr(6'h20, 32'hF);
    endtask

    task automatic test_multi();
        reg_wr(6'd6, 32'd0);
        prog_ch(0, 32'h0000_0200, 5'd0, 4'd4, 8'd0);
        prog_ch(3, 32'h0000_0200, 5'd0, 4'd4, 8'd0);
        bus_acc(32'h0000_0200, 1'b0, 1'b0);
        tick();
        checks++; if (evt !== 1'b1) begin errors++; $display("FAIL multi_evt got %0b exp 1", evt); end
        checks++; if (matched !== 4'b1001) begin errors++; $display("FAIL multi_matched got %b exp 1001", matched); end
        tick();
        checks++; if (evt !== 1'b0) begin errors++; $display("FAIL multi_single_pulse got %0b exp 0", evt); end
        reg_wr(6'h20, 32'h1);
        checks++; if (matched !== 4'b1000) begin errors++; $display("FAIL multi_w1c got %b exp 1000", matched); end
        reg_rd(6'h20);
        checks++; if (rdata !== 32'h8) begin errors++; $display("FAIL multi_status_rd got %h exp 8", rdata); end
        reg_wr(6'd14, 32'd0);
        clear_halt();
        reg_wr(6'h20, 32'hF);
    endtask

    task automatic test_back_to_back();
        bus_trans = 1'b1; bus_addr = 32'h0000_0200; bus_hprot = 1'b0; bus_hwrite = 1'b0;
        tick();
        checks++; if (evt !== 1'b0) begin errors++; $display("FAIL b2b_n1 got %0b exp 0", evt); end
        tick();
        bus_trans = 1'b0;
        checks++; if (evt !== 1'b1) begin errors++; $display("FAIL b2b_first got %0b exp 1", evt); end
        tick();
        checks++; if (evt !== 1'b1) begin errors++; $display("FAIL b2b_second got %0b exp 1", evt); end
        tick();
        checks++; if (evt !== 1'b0) begin errors++; $display("FAIL b2b_end got %0b exp 0", evt); end
    endtask

    task automatic test_halt();
        checks++; if (halt_req !== 1'b1) begin errors++; $display("FAIL halt_level got %0b exp 1", halt_req); end
        tick();
        checks++; if (halt_req !== 1'b1) begin errors++; $display("FAIL halt_hold got %0b exp 1", halt_req); end
        halted = 1'b1;
        tick();
        halted = 1'b0;
        checks++; if (halt_req !== 1'b0) begin errors++; $display("FAIL halt_drop got %0b exp 0", halt_req); end
        reg_wr(6'h20, 32'hF);
        debugen = 1'b0;
        bus_acc(32'h0000_0200, 1'b0, 1'b0);
        tick();
        debugen = 1'b1;
        checks++; if (evt !== 1'b0) begin errors++; $display("FAIL halt_nodebugen_evt got %0b exp 0", evt); end
        checks++; if (halt_req !== 1'b0) begin errors++; $display("FAIL halt_nodebugen_req got %0b exp 0", halt_req); end
    endtask

    task automatic test_collisions();
        bus_acc(32'h0000_0200, 1'b0, 1'b0);
        reg_wr(6'h20, 32'h1);
        checks++; if (matched[0] !== 1'b1) begin errors++; $display("FAIL coll_w1c_set got %0b exp 1", matched[0]); end
        checks++; if (evt !== 1'b1) begin errors++; $display("FAIL coll_w1c_evt got %0b exp 1", evt); end
        clear_halt();
        reg_wr(6'h20, 32'hF);
        reg_wr(6'd3, 32'd1);
        bus_acc(32'h0000_0200, 1'b0, 1'b0);
        bus_acc(32'h0000_0200, 1'b0, 1'b0);
        reg_wr(6'd2, 32'd4);
        checks++; if (evt !== 1'b0) begin errors++; $display("FAIL coll_discard_evt got %0b exp 0", evt); end
        bus_acc(32'h0000_0200, 1'b0, 1'b0);
        tick();
        checks++; if (evt !== 1'b0) begin errors++; $display("FAIL coll_reload_first got %0b exp 0", evt); end
        bus_acc(32'h0000_0200, 1'b0, 1'b0);
        tick();
        checks++; if (evt !== 1'b1) begin errors++; $display("FAIL coll_reload_second got %0b exp 1", evt); end
        clear_halt();
        reg_wr(6'h20, 32'hF);
    endtask

    task automatic test_bounds();
        reg_wr(6'd8, 32'hDEAD_BEEF);
        reg_rd(6'd8);
        checks++; if (rdata2 !== 32'h0) begin errors++; $display("FAIL bounds_ch2_n2 got %h exp 0", rdata2); end
        checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bounds_ch2_n4 got %h exp deadbeef", rdata); end
        reg_wr(6'd16, 32'h1234_5678);
        reg_rd(6'd16);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL bounds_ch4 got %h exp 0", rdata); end
        reg_rd(6'h21);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL bounds_0x21 got %h exp 0", rdata); end
        reg_wr(6'd5, 32'hFFFF_FFFF);
        reg_rd(6'd5);
        checks++; if (rdata !== 32'h1F) begin errors++; $display("FAIL bounds_mask_bits got %h exp 1f", rdata); end
        reg_wr(6'd6, 32'h9);
        reg_rd(6'd6);
        checks++; if (rdata !== 32'h9) begin errors++; $display("FAIL bounds_func9 got %h exp 9", rdata); end
        bus_acc(32'h2000_0100, 1'b1, 1'b1);
        tick();
        checks++; if (evt !== 1'b0) begin errors++; $display("FAIL bounds_func9_evt got %0b exp 0", evt); end
    endtask

    task automatic test_reset_mid();
        reg_rd(6'd0);
        bus_acc(32'h0000_0200, 1'b0, 1'b0);
        dbg_reset = 1'b1;
        tick();
        dbg_reset = 1'b0;
        checks++; if (evt !== 1'b0) begin errors++; $display("FAIL rstmid_evt got %0b exp 0", evt); end
        checks++; if (halt_req !== 1'b0) begin errors++; $display("FAIL rstmid_halt got %0b exp 0", halt_req); end
        checks++; if (matched !== 4'b0) begin errors++; $display("FAIL rstmid_matched got %b exp 0000", matched); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rstmid_rdata got %h exp 0", rdata); end
        checks++; if ({evt2, halt_req2, matched2} !== 4'b0) begin
            errors++; $display("FAIL rstmid_dut2 got %b exp 0000", {evt2, halt_req2, matched2});
        end
        tick();
        checks++; if (evt !== 1'b0) begin errors++; $display("FAIL rstmid_late_evt got %0b exp 0", evt); end
        reg_rd(6'd2);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rstmid_func0 got %h exp 0", rdata); end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_mask_threshold();
        test_multi();
        prog_ch(0, 32'h0000_0200, 5'd0, 4'd4, 8'd0);
        test_back_to_back();
        test_halt();
        test_collisions();
        test_bounds();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
